// File: rtl/axis_frame_sink_if.sv
// AXI4-Stream pixel channel: one 32-bit beat per pixel, tuser = SOF, tlast = EOF.
interface axis_frame_sink_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/axis_frame_sink.sv
// axis_frame_sink: receive endpoint for the AXI4-Stream pixel protocol.
// Accepts frames with optional LFSR-driven backpressure, tracks raster
// position, flags framing errors (sticky), and counts good frames.
// Optional feature: define FRAME_CHECKSUM_EN to compute a rotate-xor
// checksum per good frame; otherwise frame_checksum is tied to zero.
module axis_frame_sink #(
  parameter int          X_SIZE    = 640,
  parameter int          Y_SIZE    = 480,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                aclk,
  input  logic                areset,
  axis_frame_sink_if.slave    s_stream,
  input  logic                stall_en,
  input  logic                err_clear,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_count,
  output logic [3:0]          err_flags,
  output logic [31:0]         frame_checksum
);

  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  typedef enum logic {WAIT_SOF, IN_FRAME} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic [3:0]    err_q, err_d;
  logic          frame_done_q, frame_done_d;
  logic          tready_q, tready_d;
  logic [15:0]   lfsr_q, lfsr_d;

  logic       accept;
  logic       last_pos;
  logic       sof_beat;    // accepted beat that (re)starts a frame
  logic       step_beat;   // accepted mid-frame beat that only advances position
  logic       good_frame;  // accepted final beat of a correctly framed frame
  logic [3:0] err_set;

  assign accept   = s_stream.tvalid & tready_q;
  assign last_pos = (x_q == X_LAST) && (y_q == Y_LAST);

  // Next-state, raster position, error detection, frame counting and backpressure.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    err_set    = '0;
    sof_beat   = 1'b0;
    step_beat  = 1'b0;
    good_frame = 1'b0;

    if (accept) begin
      if (s_stream.tkeep != 4'b1111) err_set[3] = 1'b1;

      unique case (state_q)
        WAIT_SOF: begin
          // X_SIZE >= 2, so a beat carrying both SOF and EOF is always a short frame.
          if (s_stream.tuser) begin
            if (s_stream.tlast) err_set[1] = 1'b1;
            else                sof_beat   = 1'b1;
          end
        end
        IN_FRAME: begin
          if (s_stream.tuser) begin
            err_set[0] = 1'b1;
            if (s_stream.tlast) begin
              err_set[1] = 1'b1;
              state_d    = WAIT_SOF;
              x_d        = '0;
              y_d        = '0;
            end else begin
              sof_beat = 1'b1;
            end
          end else if (last_pos) begin
            if (s_stream.tlast) good_frame = 1'b1;
            else                err_set[2] = 1'b1;
            state_d = WAIT_SOF;
            x_d     = '0;
            y_d     = '0;
          end else if (s_stream.tlast) begin
            err_set[1] = 1'b1;
            state_d    = WAIT_SOF;
            x_d        = '0;
            y_d        = '0;
          end else begin
            step_beat = 1'b1;
          end
        end
        default: state_d = WAIT_SOF;
      endcase

      // The SOF beat occupies (0,0); the counters hold the next beat's position.
      if (sof_beat) begin
        state_d = IN_FRAME;
        x_d     = XW'(1);
        y_d     = '0;
      end else if (step_beat) begin
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
    end

    // A fresh error wins over a simultaneous clear.
    err_d         = (err_clear ? 4'b0000 : err_q) | err_set;
    frame_count_d = good_frame ? frame_count_q + 16'd1 : frame_count_q;
    frame_done_d  = good_frame;

    // Fibonacci LFSR, taps 16,14,13,11; runs every cycle independent of stall_en.
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    tready_d = stall_en ? lfsr_d[0] : 1'b1;
  end

  // State registers with asynchronous reset; reset aborts any frame silently.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= WAIT_SOF;
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      err_q         <= '0;
      frame_done_q  <= 1'b0;
      tready_q      <= 1'b0;
      lfsr_q        <= LFSR_SEED;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
      frame_done_q  <= frame_done_d;
      tready_q      <= tready_d;
      lfsr_q        <= lfsr_d;
    end
  end

  assign s_stream.tready = tready_q;
  assign busy            = (state_q == IN_FRAME);
  assign frame_done      = frame_done_q;
  assign frame_count     = frame_count_q;
  assign err_flags       = err_q;

`ifdef FRAME_CHECKSUM_EN
  logic [31:0] cksum_q, cksum_d;
  logic [31:0] frame_checksum_q, frame_checksum_d;
  logic [31:0] cksum_step;

  // Running rotate-xor checksum; only a good frame publishes it.
  always_comb begin
    cksum_step       = {cksum_q[30:0], cksum_q[31]} ^ s_stream.tdata;
    cksum_d          = cksum_q;
    frame_checksum_d = frame_checksum_q;
    if (sof_beat)       cksum_d = s_stream.tdata;
    else if (step_beat) cksum_d = cksum_step;
    if (good_frame)     frame_checksum_d = cksum_step;
  end

  // Checksum registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cksum_q          <= '0;
      frame_checksum_q <= '0;
    end else begin
      cksum_q          <= cksum_d;
      frame_checksum_q <= frame_checksum_d;
    end
  end

  assign frame_checksum = frame_checksum_q;
`else
  assign frame_checksum = 32'h0;
`endif

endmodule
